// File: rtl/lpc_host_ctrl_seq.sv
// Turns valid/ready LPC cycle requests into lpc_host ctrl_* strobes and returns read data or a timeout.
// Latency: lframe falls on the acceptance edge; the response follows host completion by one edge. Requests are held off (req_ready=0) while busy.
module lpc_host_ctrl_seq #(
    parameter int LFRAME_CYCLES  = 2,
    parameter int RST_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic        req_mem_i,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_rdata_o,
    output logic        rsp_timeout_o,
    output logic        ctrl_nrst_o,
    output logic        ctrl_lframe_o,
    output logic        ctrl_rd_status_o,
    output logic        ctrl_wr_status_o,
    output logic        ctrl_memory_cycle_o,
    output logic [15:0] ctrl_addr_o,
    output logic [7:0]  ctrl_data_o,
    input  logic [7:0]  ctrl_data_i,
    input  logic        ctrl_ready_i
);

    localparam int MAX_A = (LFRAME_CYCLES > RST_CYCLES) ? LFRAME_CYCLES : RST_CYCLES;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] LF_LAST = CW'(LFRAME_CYCLES);
    localparam logic [CW-1:0] RS_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        BUS_RST,
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state               <= BUS_RST;
            cnt                 <= '0;
            req_ready_o         <= 1'b0;
            rsp_valid_o         <= 1'b0;
            rsp_rdata_o         <= 8'h00;
            rsp_timeout_o       <= 1'b0;
            ctrl_nrst_o         <= 1'b0;
            ctrl_lframe_o       <= 1'b1;
            ctrl_rd_status_o    <= 1'b0;
            ctrl_wr_status_o    <= 1'b0;
            ctrl_memory_cycle_o <= 1'b0;
            ctrl_addr_o         <= 16'h0000;
            ctrl_data_o         <= 8'h00;
        end else begin
            // Response fields are single-clock pulses; states below override.
            rsp_valid_o   <= 1'b0;
            rsp_timeout_o <= 1'b0;
            rsp_rdata_o   <= 8'h00;

            case (state)
                BUS_RST: begin
                    if (cnt >= RS_LAST) begin
                        ctrl_nrst_o <= 1'b1;
                        cnt         <= '0;
                        req_ready_o <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        ctrl_wr_status_o    <= req_write_i;
                        ctrl_rd_status_o    <= ~req_write_i;
                        ctrl_memory_cycle_o <= req_mem_i;
                        ctrl_addr_o         <= req_addr_i;
                        ctrl_data_o         <= req_wdata_i;
                        ctrl_lframe_o       <= 1'b0;
                        req_ready_o         <= 1'b0;
                        cnt                 <= ONE;
                        state               <= START;
                    end else begin
                        req_ready_o <= ctrl_ready_i;
                    end
                end

                START: begin
                    if (cnt >= LF_LAST) begin
                        ctrl_lframe_o <= 1'b1;
                        cnt           <= '0;
                        state         <= WAIT_BUSY;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                WAIT_BUSY, WAIT_DONE: begin
                    if (state == WAIT_BUSY && !ctrl_ready_i) begin
                        cnt   <= '0;
                        state <= WAIT_DONE;
                    end else if (state == WAIT_DONE && ctrl_ready_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= ctrl_rd_status_o ? ctrl_data_i : 8'h00;
                        state       <= RESP;
                    end else if (cnt >= TO_LAST) begin
                        // Host stalled (or never went busy): abort and recover the bus.
                        rsp_valid_o      <= 1'b1;
                        rsp_timeout_o    <= 1'b1;
                        ctrl_nrst_o      <= 1'b0;
                        ctrl_rd_status_o <= 1'b0;
                        ctrl_wr_status_o <= 1'b0;
                        cnt              <= '0;
                        state            <= BUS_RST;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                RESP: begin
                    ctrl_rd_status_o <= 1'b0;
                    ctrl_wr_status_o <= 1'b0;
                    state            <= IDLE;
                end

                default: state <= BUS_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_host_ctrl_seq.sv
// Bench for lpc_host_ctrl_seq: stub LPC host with a peripheral store, request-level response model.
module tb_lpc_host_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_mem = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic        ctrl_nrst, ctrl_lframe, ctrl_rd, ctrl_wr, ctrl_mem;
    logic [15:0] ctrl_addr;
    logic [7:0]  ctrl_dout;
    logic [7:0]  ctrl_din = 8'hEE;
    logic        ctrl_ready = 1'b1;

    always #5 clk = ~clk;

    lpc_host_ctrl_seq dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_write_i        (req_write),
        .req_mem_i          (req_mem),
        .req_addr_i         (req_addr),
        .req_wdata_i        (req_wdata),
        .rsp_valid_o        (rsp_valid),
        .rsp_rdata_o        (rsp_rdata),
        .rsp_timeout_o      (rsp_timeout),
        .ctrl_nrst_o        (ctrl_nrst),
        .ctrl_lframe_o      (ctrl_lframe),
        .ctrl_rd_status_o   (ctrl_rd),
        .ctrl_wr_status_o   (ctrl_wr),
        .ctrl_memory_cycle_o(ctrl_mem),
        .ctrl_addr_o        (ctrl_addr),
        .ctrl_data_o        (ctrl_dout),
        .ctrl_data_i        (ctrl_din),
        .ctrl_ready_i       (ctrl_ready)
    );

    typedef struct {
        logic        w;
        logic        m;
        logic [15:0] a;
        logic [7:0]  d;
    } req_t;

    typedef struct {
        logic       to;
        logic [7:0] rd;
    } rsp_t;

    req_t issued_q[$];
    rsp_t exp_q[$];
    logic [7:0] model_mem  [logic [16:0]];
    logic [7:0] periph_mem [logic [16:0]];

    int n_checks = 0;
    int n_pass   = 0;
    int rsp_cnt  = 0;
    int to_cnt   = 0;
    int mode     = 0;   // 0 responsive host, 1 never goes busy, 2 never completes
    logic [7:0]  last_rsp_rdata = 8'h00;
    logic        last_rsp_to = 1'b0;
    req_t        last_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_nrst"},      ctrl_nrst, 0);
        check({tag, "_lframe"},    ctrl_lframe, 1);
        check({tag, "_rd"},        ctrl_rd, 0);
        check({tag, "_wr"},        ctrl_wr, 0);
        check({tag, "_mem"},       ctrl_mem, 0);
        check({tag, "_addr"},      ctrl_addr, 0);
        check({tag, "_data"},      ctrl_dout, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_to"},    rsp_timeout, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    endtask

    task automatic do_req(input logic w, input logic m, input logic [15:0] a, input logic [7:0] d,
                          input bit want_rsp, input bit to);
        req_t r;
        rsp_t e;
        int   n;
        r.w = w; r.m = m; r.a = a; r.d = d;
        issued_q.push_back(r);
        if (want_rsp) begin
            e.to = to;
            e.rd = 8'h00;
            if (!to) begin
                if (w) model_mem[{m, a}] = d;
                else if (model_mem.exists({m, a})) e.rd = model_mem[{m, a}];
            end
            exp_q.push_back(e);
        end
        req_write = w; req_mem = m; req_addr = a; req_wdata = d; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("req_accepted", (n < 2000), 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rsp_wait_outstanding", exp_q.size(), 0);
    endtask

    task automatic wait_nrst_high();
        int n;
        n = 0;
        while (!ctrl_nrst && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("nrst_release", ctrl_nrst, 1);
    endtask

    // Stub host plus per-cycle checks against the request-level model.
    initial begin
        logic       prev_lf, prev_rv, nrun_on;
        int         hs, lf_len, busy_n, nrun;
        logic [7:0] rdata_next;
        req_t       r;
        rsp_t       e;
        prev_lf = 1; prev_rv = 0; nrun_on = 0; hs = 0; lf_len = 0; busy_n = 0; nrun = 0;
        rdata_next = 8'hEE;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                hs = 0; ctrl_ready = 1'b1; ctrl_din = 8'hEE;
                prev_lf = 1; prev_rv = 0; nrun_on = 0;
            end else begin
                if (hs == 4) begin
                    check("rsp_latency", rsp_valid, 1);
                    hs = 0;
                    ctrl_din = 8'hEE;
                end
                if (rsp_valid) begin
                    check("rsp_single_pulse", prev_rv, 0);
                    check("rsp_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("rsp_timeout", rsp_timeout, e.to);
                        check("rsp_rdata", rsp_rdata, e.rd);
                        check("rsp_addr_stable", ctrl_addr, last_seen.a);
                        check("rsp_mem_stable", ctrl_mem, last_seen.m);
                    end
                    rsp_cnt++;
                    if (rsp_timeout) begin
                        to_cnt++;
                        nrun_on = 1;
                        nrun = 0;
                    end
                    last_rsp_rdata = rsp_rdata;
                    last_rsp_to = rsp_timeout;
                end else begin
                    check("idle_rdata_zero", rsp_rdata, 0);
                    check("idle_timeout_zero", rsp_timeout, 0);
                end
                prev_rv = rsp_valid;
                if (nrun_on) begin
                    if (!ctrl_nrst) nrun++;
                    else begin
                        check("recovery_nrst_len", nrun, 8);
                        nrun_on = 0;
                    end
                end
                if (prev_lf && !ctrl_lframe) begin
                    check("issue_expected", (issued_q.size() != 0), 1);
                    if (issued_q.size() != 0) begin
                        r = issued_q.pop_front();
                        check("bus_addr", ctrl_addr, r.a);
                        check("bus_mem", ctrl_mem, r.m);
                        check("bus_wr", ctrl_wr, r.w);
                        check("bus_rd", ctrl_rd, !r.w);
                        check("bus_data", ctrl_dout, r.d);
                    end
                    check("busy_req_ready", req_ready, 0);
                    last_seen.a = ctrl_addr; last_seen.m = ctrl_mem;
                    last_seen.w = ctrl_wr;   last_seen.d = ctrl_dout;
                    if (ctrl_wr) begin
                        periph_mem[{ctrl_mem, ctrl_addr}] = ctrl_dout;
                        rdata_next = 8'hEE;
                    end else begin
                        rdata_next = periph_mem.exists({ctrl_mem, ctrl_addr}) ?
                                     periph_mem[{ctrl_mem, ctrl_addr}] : 8'h00;
                    end
                    hs = 1;
                    lf_len = 1;
                end else if (hs == 1) begin
                    if (!ctrl_lframe) lf_len++;
                    else begin
                        check("lframe_low_len", lf_len, 2);
                        if (mode == 0) begin
                            ctrl_ready = 1'b0; busy_n = 0; hs = 3;
                        end else if (mode == 1) begin
                            hs = 0;
                        end else begin
                            ctrl_ready = 1'b0; hs = 5;
                        end
                    end
                end else if (hs == 3) begin
                    busy_n++;
                    if (busy_n == 3) begin
                        ctrl_ready = 1'b1;
                        ctrl_din = rdata_next;
                        hs = 4;
                    end
                end
                prev_lf = ctrl_lframe;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, c0, t0;

        // T1: reset hold and release
        repeat (3) @(negedge clk);
        check_reset_vals("t1_reset");
        rst_i = 1'b0;
        n = 0;
        while (!ctrl_nrst && n < 50) begin
            n++;
            check("t1_req_ready_low", req_ready, 0);
            @(negedge clk);
        end
        check("t1_nrst_low_len", n, 8);
        repeat (3) @(negedge clk);

        // T2: I/O write
        mode = 0;
        do_req(1'b1, 1'b0, 16'hF0F0, 8'h5A, 1, 0);
        wait_rsp();
        check("t2_seen_addr", last_seen.a, 16'hF0F0);
        check("t2_seen_data", last_seen.d, 8'h5A);
        check("t2_seen_wr", last_seen.w, 1);
        check("t2_rdata", last_rsp_rdata, 8'h00);
        check("t2_timeout", last_rsp_to, 0);
        check("t2_periph", periph_mem[{1'b0, 16'hF0F0}], 8'h5A);

        // T3: I/O read of a preset peripheral register
        periph_mem[{1'b0, 16'h0010}] = 8'hA5;
        model_mem[{1'b0, 16'h0010}]  = 8'hA5;
        c0 = rsp_cnt;
        do_req(1'b0, 1'b0, 16'h0010, 8'h00, 1, 0);
        wait_rsp();
        repeat (5) @(negedge clk);
        check("t3_rdata", last_rsp_rdata, 8'hA5);
        check("t3_one_pulse", rsp_cnt - c0, 1);

        // T4: memory writes then reads back, 0x0000..0x0080
        c0 = rsp_cnt;
        t0 = to_cnt;
        for (int i = 0; i <= 128; i++) begin
            do_req(1'b1, 1'b1, 16'(i), 8'(8'hBB + i), 1, 0);
            wait_rsp();
        end
        for (int i = 0; i <= 128; i++) begin
            do_req(1'b0, 1'b1, 16'(i), 8'h00, 1, 0);
            wait_rsp();
            if (i == 0) check("t4_read_first", last_rsp_rdata, 8'hBB);
        end
        check("t4_read_last", last_rsp_rdata, 8'h3B);
        check("t4_rsp_count", rsp_cnt - c0, 258);
        check("t4_no_timeouts", to_cnt - t0, 0);

        // T5: host never goes busy -> timeout in WAIT_BUSY
        repeat (3) @(negedge clk);
        mode = 1;
        do_req(1'b0, 1'b0, 16'h1234, 8'h00, 1, 1);
        n = 0;
        while (!ctrl_lframe && n < 20) begin
            @(negedge clk);
            n++;
        end
        k = 0;
        while (!rsp_valid && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("t5_timeout_latency", k, 256);
        check("t5_timeout_flag", rsp_timeout, 1);
        check("t5_timeout_rdata", rsp_rdata, 0);
        check("t5_nrst_low", ctrl_nrst, 0);
        wait_nrst_high();
        mode = 0;
        repeat (4) @(negedge clk);

        // T6: reset while the host is stuck busy
        mode = 2;
        do_req(1'b0, 1'b0, 16'h0042, 8'h00, 0, 0);
        n = 0;
        while (!ctrl_lframe && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("t6_in_wait_done_rd", ctrl_rd, 1);
        rst_i = 1'b1;
        @(negedge clk);
        check_reset_vals("t6_reset");
        @(negedge clk);
        mode = 0;
        rst_i = 1'b0;
        wait_nrst_high();
        repeat (4) @(negedge clk);

        // Recovery: a normal read works again
        do_req(1'b0, 1'b0, 16'h0010, 8'h00, 1, 0);
        wait_rsp();
        check("post_rst_rdata", last_rsp_rdata, 8'hA5);
        repeat (5) @(negedge clk);
        check("end_issued_drained", issued_q.size(), 0);
        check("end_rsp_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
